// File: rtl/fsk_pkg.sv
// fsk_pkg: shared types and helpers for the M-ary FSK modulator.
// Mode codes, FSM states, tone-word math and sine ROM contents.
package fsk_pkg;

  localparam logic [1:0] MODE_2FSK  = 2'b00;
  localparam logic [1:0] MODE_4FSK  = 2'b01;
  localparam logic [1:0] MODE_8FSK  = 2'b10;
  localparam logic [1:0] MODE_16FSK = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // pi in Q30
  localparam longint PI_Q30 = 64'sd3373259426;

  function automatic logic [63:0] tone_word(
    input logic [3:0]  idx,
    input logic [63:0] base,
    input logic [63:0] step
  );
    return base + 64'(idx) * step;
  endfunction

  function automatic logic [3:0] sym_mask(input logic [1:0] mode);
    logic [3:0] m;
    m = 4'h1;
    unique case (mode)
      MODE_2FSK:  m = 4'h1;
      MODE_4FSK:  m = 4'h3;
      MODE_8FSK:  m = 4'h7;
      MODE_16FSK: m = 4'hF;
    endcase
    return m;
  endfunction

  // round(amp*sin(2*pi*i/2^aw)) via a Q30 Taylor series,
  // evaluated at elaboration time to fill the ROM.
  function automatic int sine_q(
    input int i,
    input int aw,
    input int amp
  );
    longint x;
    longint x2;
    longint t;
    longint s;
    x  = (PI_Q30 * 2 * longint'(i)) >>> aw;
    x2 = (x * x) >>> 30;
    t  = x;
    s  = x;
    for (int k = 1; k < 8; k++) begin
      t = -((t * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      s = s + t;
    end
    return int'((s * longint'(amp) + (longint'(1) <<< 29)) >>> 30);
  endfunction

endpackage

// File: rtl/fsk_sine_lut.sv
// fsk_sine_lut: quarter-wave sine ROM with quadrant fold/negate.
// Ports: i_clk, i_rst_n (sync, active low), i_valid/i_addr in;
//   o_valid/o_sample out two cycles later, o_busy = any stage valid.
//   o_sample is forced to 0 when o_valid is low.
import fsk_pkg::*;

module fsk_sine_lut #(
  parameter int LUT_AW = 10,
  parameter int AMP    = 8000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic [LUT_AW-1:0]        i_addr,
  output logic                     o_valid,
  output logic signed [13:0]       o_sample,
  output logic                     o_busy
);

  localparam int QW = LUT_AW - 2;
  localparam int QN = 1 << QW;

  logic [12:0]   w_rom [QN];
  logic [QW-1:0] w_low;
  logic [QW-1:0] w_maddr;
  logic          w_peak;
  logic [12:0]   w_mag;
  logic signed [13:0] w_s;

  logic [12:0] r_mag;
  logic        r_neg;
  logic        r_v1;

  for (genvar g = 0; g < QN; g++) begin : g_rom
    localparam logic [12:0] V = 13'(sine_q(g, LUT_AW, AMP));
    assign w_rom[g] = V;
  end

  // Odd quadrants read the table mirrored (QN - low); low==0
  // there lands on the peak, which the table does not hold.
  assign w_low   = i_addr[QW-1:0];
  assign w_maddr = i_addr[QW] ? (~w_low + 1'b1) : w_low;
  assign w_peak  = i_addr[QW] && (w_low == '0);
  assign w_mag   = w_peak ? 13'(AMP) : w_rom[w_maddr];
  assign w_s     = $signed({1'b0, r_mag});

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mag    <= '0;
      r_neg    <= 1'b0;
      r_v1     <= 1'b0;
      o_valid  <= 1'b0;
      o_sample <= '0;
    end else begin
      r_mag    <= w_mag;
      r_neg    <= i_addr[LUT_AW-1];
      r_v1     <= i_valid;
      o_valid  <= r_v1;
      o_sample <= !r_v1 ? '0 : (r_neg ? -w_s : w_s);
    end
  end

  assign o_busy = r_v1 | o_valid;

endmodule

// File: rtl/fsk_modulator.sv
// fsk_modulator: M-ary FSK transmitter, NCO + quarter-wave sine.
// Ports: clk, reset (sync, active low), mode/sym_in/sym_valid/sym_ready
//   symbol handshake; dac_out/dac_valid sample stream; busy; underrun.
// Build option: FSK_PHASE_CONT_EN keeps phase across gapless symbols.
import fsk_pkg::*;

module fsk_modulator #(
  parameter int              SYM_LEN = 1024,
  parameter int              PH_W    = 32,
  parameter logic [PH_W-1:0] F_BASE  = 32'h0040_0000,
  parameter logic [PH_W-1:0] F_STEP  = 32'h0040_0000,
  parameter int              LUT_AW  = 10,
  parameter int              AMP     = 8000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic [3:0]         sym_in,
  input  logic               sym_valid,
  output logic               sym_ready,
  output logic signed [13:0] dac_out,
  output logic               dac_valid,
  output logic               busy,
  output logic               underrun
);

  localparam int CW = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(SYM_LEN - 1);

  state_t          r_state;
  state_t          w_nstate;
  logic [PH_W-1:0] r_phase;
  logic [PH_W-1:0] r_fword;
  logic [PH_W-1:0] w_fword;
  logic [CW-1:0]   r_count;
  logic            r_underrun;
  logic [3:0]      w_idx;
  logic            w_last;
  logic            w_accept;
  logic            w_under;
  logic            w_run;
  logic            w_pipe_busy;

  assign w_idx   = sym_in & sym_mask(mode);
  assign w_fword = PH_W'(tone_word(w_idx, 64'(F_BASE), 64'(F_STEP)));
  assign w_run   = (r_state == RUN);

  always_comb begin
    w_nstate  = r_state;
    sym_ready = 1'b0;
    w_under   = 1'b0;
    w_last    = w_run && (r_count == LAST);
    unique case (r_state)
      IDLE: begin
        sym_ready = reset;
        if (sym_valid && reset) w_nstate = RUN;
      end
      RUN: begin
        if (w_last) begin
          sym_ready = reset;
          if (!sym_valid) begin
            w_nstate = IDLE;
            w_under  = 1'b1;
          end
        end
      end
    endcase
    w_accept = sym_ready & sym_valid;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_phase    <= '0;
      r_count    <= '0;
      r_fword    <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_underrun <= w_under;
      if (w_accept) begin
        r_fword <= w_fword;
        r_count <= '0;
`ifdef FSK_PHASE_CONT_EN
        r_phase <= w_run ? r_phase + r_fword : '0;
`else
        r_phase <= '0;
`endif
      end else if (w_run) begin
        r_count <= w_last ? '0 : r_count + 1'b1;
        r_phase <= w_last ? '0 : r_phase + r_fword;
      end
    end
  end

  fsk_sine_lut #(
    .LUT_AW (LUT_AW),
    .AMP    (AMP)
  ) u_lut (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_valid  (w_run),
    .i_addr   (r_phase[PH_W-1 -: LUT_AW]),
    .o_valid  (dac_valid),
    .o_sample (dac_out),
    .o_busy   (w_pipe_busy)
  );

  assign busy     = w_run | w_pipe_busy;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_fsk_modulator.sv
// tb_fsk_modulator: directed vectors and sequences for fsk_modulator.
// Second instance uses SYM_LEN=1000 for the symbol-boundary phase check.
module tb_fsk_modulator;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] mode = '0;
  logic [3:0] sym_in = '0;
  logic sym_valid = 1'b0;
  logic sym_ready, dac_valid, busy, underrun;
  logic signed [13:0] dac_out;

  logic [1:0] mode2 = '0;
  logic [3:0] sym2 = '0;
  logic valid2 = 1'b0;
  logic ready2, dv2, busy2, und2;
  logic signed [13:0] dout2;

  fsk_modulator u_dut (
    .clk(clk), .reset(reset), .mode(mode), .sym_in(sym_in),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .dac_out(dac_out),
    .dac_valid(dac_valid), .busy(busy), .underrun(underrun)
  );

  fsk_modulator #(.SYM_LEN(1000)) u_dut2 (
    .clk(clk), .reset(reset), .mode(mode2), .sym_in(sym2),
    .sym_valid(valid2), .sym_ready(ready2), .dac_out(dout2),
    .dac_valid(dv2), .busy(busy2), .underrun(und2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] sym;
    int         tone;
    int         xings;
  } vec_t;

  vec_t tbl[7];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int first_v, last_v, nv, n_under, under_cyc, busy_fall, zero_bad, acc_cyc;
  bit prev_busy = 1'b0;
  int q[$];
  int q2[$];

  function automatic int model(input int idx);
    real v;
    v = 8000.0 * $sin(2.0 * 3.141592653589793 * real'(idx) / 1024.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  task automatic chk(input string nm, input bit ok,
                     input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (dac_valid) begin
      q.push_back(int'(dac_out));
      nv++;
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end else if (dac_out != 0) begin
      zero_bad++;
    end
    if (underrun) begin
      n_under++;
      under_cyc = cyc;
    end
    if (prev_busy && !busy) busy_fall = cyc;
    prev_busy = busy;
    if (dv2) q2.push_back(int'(dout2));
  endtask

  task automatic clr();
    q.delete();
    nv = 0;
    first_v = -1;
    last_v = -1;
    n_under = 0;
    under_cyc = -1;
    busy_fall = -1;
    zero_bad = 0;
  endtask

  task automatic send(input logic [1:0] m, input logic [3:0] s);
    int w;
    w = 0;
    mode = m;
    sym_in = s;
    sym_valid = 1'b1;
    #1;
    while (!sym_ready && w < 3000) begin
      tick();
      w++;
    end
    chk("accept wait", w < 3000, w, 3000);
    tick();
    acc_cyc = cyc;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((busy || busy2) && w < 3000) begin
      tick();
      w++;
    end
    chk("drain wait", w < 3000, w, 3000);
    repeat (4) tick();
  endtask

  task automatic check_seg(input string nm, input int qq[$],
                           input int base, input int len,
                           input int i0, input int st, input int exp_x);
    int bad, x, pk, fa, fe;
    bad = 0; x = 0; pk = 0; fa = 0; fe = 0;
    for (int k = 0; k < len; k++) begin
      int e, a, b, j;
      e = model((i0 + st * k) % 1024);
      a = (base + k < qq.size()) ? qq[base + k] : 99999;
      j = base + ((k + 1) % len);
      b = (j < qq.size()) ? qq[j] : 0;
      if (a - e > 1 || e - a > 1) begin
        if (bad == 0) begin
          fa = a;
          fe = e;
        end
        bad++;
      end
      if ((a >= 0) != (b >= 0)) x++;
      if ((a < 0 ? -a : a) > pk) pk = (a < 0 ? -a : a);
    end
    chk({nm, " samples"}, bad == 0, fa, fe);
    if (exp_x >= 0) begin
      chk({nm, " crossings"}, x == exp_x, x, exp_x);
      chk({nm, " peak"}, pk >= 7999 && pk <= 8001, pk, 8000);
    end
  endtask

  initial begin
    int w;
    tbl[0] = '{2'b00, 4'd0,  0, 2};
    tbl[1] = '{2'b00, 4'd1,  1, 4};
    tbl[2] = '{2'b00, 4'hF,  1, 4};
    tbl[3] = '{2'b01, 4'hE,  2, 6};
    tbl[4] = '{2'b10, 4'd5,  5, 12};
    tbl[5] = '{2'b10, 4'hE,  6, 14};
    tbl[6] = '{2'b11, 4'd9,  9, 20};

    clr();
    repeat (3) tick();
    chk("rst dac_valid", dac_valid == 1'b0, dac_valid, 0);
    chk("rst dac_out", dac_out == 0, dac_out, 0);
    chk("rst busy", busy == 1'b0, busy, 0);
    chk("rst underrun", underrun == 1'b0, underrun, 0);
    chk("rst sym_ready", sym_ready == 1'b0, sym_ready, 0);
    reset = 1'b1;
    #1;
    chk("post-rst sym_ready", sym_ready == 1'b1, sym_ready, 1);

    for (int i = 0; i < 7; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      clr();
      send(tbl[i].mode, tbl[i].sym);
      sym_valid = 1'b0;
      drain();
      chk({nm, " count"}, nv == 1024, nv, 1024);
      chk({nm, " latency"}, first_v == acc_cyc + 2, first_v - acc_cyc, 2);
      check_seg(nm, q, 0, 1024, 0, tbl[i].tone + 1, tbl[i].xings);
      chk({nm, " underrun n"}, n_under == 1, n_under, 1);
      chk({nm, " underrun pos"}, under_cyc == last_v - 1,
          under_cyc - last_v, -1);
      chk({nm, " busy fall"}, busy_fall == under_cyc + 2,
          busy_fall - under_cyc, 2);
      chk({nm, " idle zero"}, zero_bad == 0, zero_bad, 0);
    end

    clr();
    send(2'b00, 4'd0);
    send(2'b00, 4'd1);
    send(2'b00, 4'd0);
    sym_valid = 1'b0;
    drain();
    chk("b2b count", nv == 3072, nv, 3072);
    chk("b2b contiguous", last_v - first_v + 1 == 3072,
        last_v - first_v + 1, 3072);
    check_seg("b2b s0", q, 0, 1024, 0, 1, 2);
    check_seg("b2b s1", q, 1024, 1024, 0, 2, 4);
    check_seg("b2b s2", q, 2048, 1024, 0, 1, 2);
    chk("b2b underrun n", n_under == 1, n_under, 1);

    clr();
    send(2'b11, 4'd3);
    sym_valid = 1'b0;
    w = 0;
    while (nv < 500 && w < 2000) begin
      tick();
      w++;
    end
    chk("mid wait", w < 2000, w, 2000);
    reset = 1'b0;
    tick();
    chk("mid rst dac_valid", dac_valid == 1'b0, dac_valid, 0);
    chk("mid rst dac_out", dac_out == 0, dac_out, 0);
    chk("mid rst busy", busy == 1'b0, busy, 0);
    chk("mid rst sym_ready", sym_ready == 1'b0, sym_ready, 0);
    reset = 1'b1;
    #1;
    chk("mid rel sym_ready", sym_ready == 1'b1, sym_ready, 1);
    clr();
    send(2'b11, 4'd15);
    sym_valid = 1'b0;
    drain();
    check_seg("16fsk", q, 0, 1024, 0, 16, 32);
    chk("16fsk first", q.size() > 16 && q[0] == 0,
        q.size() > 16 ? q[0] : -1, 0);
    chk("16fsk s16", q.size() > 16 && q[16] >= 7999 && q[16] <= 8001,
        q.size() > 16 ? q[16] : -1, 8000);

    q2.delete();
    mode2 = 2'b00;
    sym2 = 4'd0;
    valid2 = 1'b1;
    #1;
    w = 0;
    while (!ready2 && w < 3000) begin
      tick();
      w++;
    end
    tick();
    sym2 = 4'd1;
    #1;
    while (!ready2 && w < 3000) begin
      tick();
      w++;
    end
    tick();
    chk("s1000 accept", w < 3000, w, 3000);
    valid2 = 1'b0;
    drain();
    chk("s1000 count", q2.size() == 2000, q2.size(), 2000);
    check_seg("s1000 sym0", q2, 0, 1000, 0, 1, -1);
`ifdef FSK_PHASE_CONT_EN
    check_seg("s1000 sym1", q2, 1000, 1000, 1000, 2, -1);
    chk("s1000 boundary step",
        q2.size() > 1000 && (q2[1000] - q2[999]) <= 100
          && (q2[999] - q2[1000]) <= 100,
        q2.size() > 1000 ? q2[1000] - q2[999] : -99999, 0);
`else
    check_seg("s1000 sym1", q2, 1000, 1000, 0, 2, -1);
    chk("s1000 sample1000", q2.size() > 1000 && q2[1000] == 0,
        q2.size() > 1000 ? q2[1000] : -99999, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
